// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit and the decoder
// that drives it.
//   MDU_WIDTH   default operand width (HI/LO are this wide)
//   MDU_*       mdu_op encodings; 11x is reserved and acts as a no-op
//   mdu_state_e iterative-engine FSM states
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: one iteration of the shared multiply/divide datapath.
// A single WIDTH+2 bit adder/subtractor serves both operations.
//   is_div_i  1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i     2*WIDTH working accumulator
//             multiply: {partial product hi, remaining multiplier bits}
//             divide:   {partial remainder, remaining dividend / quotient bits}
//   opb_i     multiplicand (multiply) or divisor (divide), magnitude only
//   acc_o     accumulator after this step
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opb_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH+1:0] x, y, res;

  always_comb begin
    x = '0;
    y = '0;
    if (is_div_i) begin
      // Shift the next dividend bit into the partial remainder, try subtracting.
      x = {1'b0, acc_i[2*WIDTH-1:WIDTH-1]};
      y = {2'b0, opb_i};
    end else begin
      // Add the multiplicand when the current multiplier LSB is set.
      x = {2'b0, acc_i[2*WIDTH-1:WIDTH]};
      y = acc_i[0] ? {2'b0, opb_i} : '0;
    end
  end

  assign res = is_div_i ? (x - y) : (x + y);

  always_comb begin
    acc_o = acc_i;
    if (is_div_i) begin
      // Borrow out means the divisor did not fit: keep the shifted remainder.
      if (res[WIDTH+1]) acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
      else              acc_o = {res[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end else begin
      // Carry becomes the new MSB; the consumed multiplier bit drops off.
      acc_o = {res[WIDTH:0], acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: iterative multiply/divide unit owning the HI/LO registers.
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset
//   start_i   one-cycle request, sampled only while idle
//   mdu_op_i  mult/multu/div/divu/mthi/mtlo (11x = no-op)
//   src_a_i   rs operand (dividend / multiplicand / mthi-mtlo data)
//   src_b_i   rt operand (divisor / multiplier)
//   busy_o    registered; high for WIDTH CALC cycles plus one FIX cycle
//   done_o    registered one-cycle pulse, HI/LO carry the new result
//   hi_o/lo_o architectural HI/LO
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       mdu_op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;   // product / quotient sign
  logic               neg_hi_q, neg_hi_d;   // remainder sign
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;

  // capture-time helpers
  logic               sgn;
  logic [WIDTH-1:0]   abs_a, abs_b;
  // fix-up helpers
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opb_i    (opb_q),
    .acc_o    (acc_step)
  );

  // mult and div are signed (op[0]=0); magnitudes feed the unsigned engine.
  always_comb begin
    sgn   = ~mdu_op_i[0];
    abs_a = (sgn && src_a_i[WIDTH-1]) ? (~src_a_i + 1'b1) : src_a_i;
    abs_b = (sgn && src_b_i[WIDTH-1]) ? (~src_b_i + 1'b1) : src_b_i;
  end

  always_comb begin
    prod = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
    quot = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem  = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    a_raw_d  = a_raw_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          unique case (mdu_op_i)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              state_d  = S_CALC;
              cnt_d    = '0;
              is_div_d = mdu_op_i[1];
              neg_lo_d = sgn & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
              neg_hi_d = sgn & src_a_i[WIDTH-1];
              div0_d   = (src_b_i == '0);
              a_raw_d  = src_a_i;
              if (mdu_op_i[1]) begin
                acc_d = {{WIDTH{1'b0}}, abs_a};
                opb_d = abs_b;
              end else begin
                acc_d = {{WIDTH{1'b0}}, abs_b};
                opb_d = abs_a;
              end
            end
            MDU_MTHI: hi_d = src_a_i;
            MDU_MTLO: lo_d = src_a_i;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (div0_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          // MIN/-1 falls out naturally: |MIN|/1 = MIN, quotient sign clear, rem 0.
          hi_d = rem;
          lo_d = quot;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      a_raw_q  <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      a_raw_q  <= a_raw_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: table vectors, hand sequences for control/reset corners,
// and random ops checked against a plain-arithmetic reference model.
module tb_mdu_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  mdu_unit dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mdu_op_i(op),
    .src_a_i(a), .src_b_i(b), .busy_o(busy), .done_o(done),
    .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue in the current cycle (so a call right after a previous run_op issues
  // in that op's done cycle), then wait for done and check timing and result.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ex_hi, input logic [31:0] ex_lo, input string name);
    int cyc, bc;
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1; bc = 0;
    while (!done && cyc < 50) begin
      if (busy) bc++;
      step();
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'd34);
    check({name, " busy cycles"}, 32'(bc), 32'd33);
    check({name, " busy in done"}, {31'b0, busy}, 32'd0);
    check({name, " hi"}, hi, ex_hi);
    check({name, " lo"}, lo, ex_lo);
  endtask

  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (o)
      MDU_MULT:  p = sx * sy;
      MDU_MULTU: p = {32'b0, x} * {32'b0, y};
      MDU_DIV: begin
        if (y == 0) p = {x, 32'hFFFFFFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      MDU_DIVU: begin
        if (y == 0) p = {x, 32'hFFFFFFFF};
        else        p = {x % y, x / y};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  initial begin
    int cyc, dcount;
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    logic [63:0] rr;

    vecs[0] = '{MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{MDU_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[7] = '{MDU_MULT,  32'd6,        32'd7,        32'd0,        32'd42};
    vecs[8] = '{MDU_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[9] = '{MDU_DIV,   32'h80000000, 32'd0,        32'h80000000, 32'hFFFFFFFF};

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) step();
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    rst = 1'b0;
    step();

    // Table: consecutive calls also exercise issue in the done cycle.
    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

    // mtlo/mthi: one-cycle write, other register untouched, no busy/done.
    step();
    op = MDU_MTLO; a = 32'hA5A5A5A5; start = 1'b1;
    step();
    op = MDU_MTHI; a = 32'h12345678;
    step();
    start = 1'b0;
    check("mthi hi", hi, 32'h12345678);
    check("mthi lo kept", lo, 32'hA5A5A5A5);
    check("mthi busy", {31'b0, busy}, 32'd0);
    check("mthi done", {31'b0, done}, 32'd0);

    // Reserved op: nothing happens.
    op = 3'b110; a = 32'h1; b = 32'h2; start = 1'b1;
    step();
    start = 1'b0;
    check("rsvd busy", {31'b0, busy}, 32'd0);
    step();
    check("rsvd done", {31'b0, done}, 32'd0);
    check("rsvd hi", hi, 32'h12345678);
    check("rsvd lo", lo, 32'hA5A5A5A5);

    // A start (mthi) arriving mid-mult is ignored.
    op = MDU_MULT; a = 32'd3; b = 32'd5; start = 1'b1;
    step();
    start = 1'b0; cyc = 1;
    while (!done && cyc < 50) begin
      if (cyc == 4) begin op = MDU_MTHI; a = 32'hDEADBEEF; start = 1'b1; end
      else start = 1'b0;
      step();
      cyc++;
    end
    start = 1'b0;
    check("ignored latency", 32'(cyc), 32'd34);
    check("ignored hi", hi, 32'd0);
    check("ignored lo", lo, 32'd15);

    // Reset part-way through a divide abandons it.
    step();
    op = MDU_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst done", {31'b0, done}, 32'd0);
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    rst = 1'b0;
    dcount = 0;
    repeat (40) begin
      step();
      if (done || busy) dcount++;
    end
    check("midrst no done", 32'(dcount), 32'd0);
    run_op(MDU_MULT, 32'd6, 32'd7, 32'd0, 32'd42, "post-reset mult");

    // Random ops against the reference model.
    for (int n = 0; n < 30; n++) begin
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) ry = ry & 32'hFF;
      rr = ref_model(ro, rx, ry);
      run_op(ro, rx, ry, rr[63:32], rr[31:0], $sformatf("rand%0d op%0d", n, ro));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
